lbist_ctrl: RTL and testbench
=============================

LBIST_CTRL -- requirements
Module: lbist_ctrl

Interface
REQ-001 Parameter N_SHIFT, default 20, scan-chain length in shift cycles per pattern (>=1).
REQ-002 Parameter N_PATTERNS, default 1024, number of LFSR patterns applied (>=1).
REQ-003 Parameter SIG_W, default 32, MISR signature width.
REQ-004 Parameter GOLDEN_SIG, default 0, expected signature, SIG_W bits.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset, with ports as listed below.
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 start  in  1  single-cycle or level request to begin a self-test run.
REQ-009 misr_sig  in  SIG_W  current MISR signature.
REQ-010 lfsr_rst  out  1  reseeds the LFSR TPG.
REQ-011 lfsr_en  out  1  advances the LFSR one state per cycle.
REQ-012 scan_en  out  1  scan-chain shift mode.
REQ-013 capture  out  1  functional capture pulse.
REQ-014 misr_rst  out  1  clears the MISR.
REQ-015 misr_en  out  1  compacts scan-out into the MISR.
REQ-016 busy  out  1  run in progress.
REQ-017 done  out  1  run finished; pass is valid.
REQ-018 pass  out  1  signature matched GOLDEN_SIG.
REQ-019 pattern_cnt  out  clog2(N_PATTERNS+1)  number of captures completed in the current run.

Function
REQ-020 The FSM SHALL have exactly these states: IDLE, INIT, SHIFT, CAPTURE, UNLOAD, COMPARE and DONE.
REQ-021 In IDLE or DONE, start=1 SHALL move the FSM to INIT on the next edge, clear pattern_cnt, and clear done and pass.
REQ-022 While busy, start SHALL be ignored.
REQ-023 INIT SHALL last 1 cycle with lfsr_rst=1, misr_rst=1, and all other control outputs 0; it SHALL then go to SHIFT.
REQ-024 SHIFT SHALL last exactly N_SHIFT cycles with scan_en=1 and lfsr_en=1; it SHALL then go to CAPTURE.
REQ-025 In SHIFT, misr_en SHALL be 0 when pattern_cnt=0 (chain content unknown) and 1 otherwise.
REQ-026 CAPTURE SHALL last 1 cycle with capture=1 and scan_en, lfsr_en and misr_en all 0; pattern_cnt SHALL increment at its end.
REQ-027 After CAPTURE, the FSM SHALL go to SHIFT if the incremented pattern_cnt < N_PATTERNS, else to UNLOAD.
REQ-028 UNLOAD SHALL last N_SHIFT cycles with scan_en=1, misr_en=1 and lfsr_en=0; it SHALL then go to COMPARE.
REQ-029 COMPARE SHALL last 1 cycle; at its end pass SHALL be registered as (misr_sig == GOLDEN_SIG); the FSM SHALL then go to DONE.
REQ-030 In DONE, done=1 and pass SHALL hold until the next start or rst.
REQ-031 busy SHALL be 1 in INIT through COMPARE inclusive and 0 in IDLE and DONE.
REQ-032 Run latency SHALL be fixed: busy for exactly 1 + N_PATTERNS*(N_SHIFT+1) + N_SHIFT + 1 cycles, with done rising in the next cycle.
REQ-033 The shift counter SHALL reload to 0 on every entry to SHIFT or UNLOAD and SHALL never wrap within a state.
REQ-034 pattern_cnt SHALL saturate at N_PATTERNS and SHALL never wrap.
REQ-035 All outputs SHALL be registered or decoded from the state register only, with no combinational path from any input.
REQ-036 The state encoding SHALL contain no unreachable legal states; any illegal encoding SHALL return to IDLE on the next edge.

Reset
REQ-037 When rst=1 at an edge, the FSM SHALL go to IDLE, and pattern_cnt, lfsr_rst, lfsr_en, scan_en, capture, misr_rst, misr_en, busy, done and pass SHALL all be 0.
REQ-038 rst SHALL override start in the same cycle.
REQ-039 rst asserted mid-run (any state) SHALL abort the run with no done pulse and no pass update.

Verification
REQ-040 With N_SHIFT=4, N_PATTERNS=3, a start pulse at edge 0 -> INIT in cycle 1; SHIFT in 2-5, 7-10 and 12-15; CAPTURE in 6, 11 and 16; UNLOAD in 17-20; COMPARE in 21; done=1 from cycle 22; busy=1 for cycles 1-21.
REQ-041 In the same run, misr_en=0 in cycles 2-5, =1 in 7-10, 12-15 and 17-20, and =0 in all CAPTURE cycles; lfsr_en=0 in 17-20.
REQ-042 misr_sig=GOLDEN_SIG during COMPARE -> pass=1 and done=1; misr_sig=GOLDEN_SIG^1 -> pass=0 and done=1.
REQ-043 rst=1 in cycle 9 of the run above -> IDLE from cycle 10, all outputs 0, pattern_cnt=0, done never asserts.
REQ-044 start held high continuously from IDLE -> exactly one run, then DONE, then a new run starts one cycle after DONE entry (restart from DONE) with pass/done cleared.
REQ-045 N_SHIFT=1, N_PATTERNS=1 -> busy for exactly 4 cycles (INIT, SHIFT, CAPTURE, UNLOAD) plus COMPARE, i.e. 5 cycles, then done.

Source files
------------

// File: rtl/lbist_ctrl.sv
// Logic BIST sequencer: reseeds the TPG, shifts/captures N_PATTERNS patterns,
// unloads the last response into the MISR and compares it to GOLDEN_SIG.
// Ports: clk, rst (sync, high), start, misr_sig in; LFSR/scan/MISR controls,
// busy, done, pass and pattern_cnt out.
module lbist_ctrl #(
  parameter int N_SHIFT = 20,
  parameter int N_PATTERNS = 1024,
  parameter int SIG_W = 32,
  parameter logic [SIG_W-1:0] GOLDEN_SIG = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [SIG_W-1:0] misr_sig,
  output logic lfsr_rst,
  output logic lfsr_en,
  output logic scan_en,
  output logic capture,
  output logic misr_rst,
  output logic misr_en,
  output logic busy,
  output logic done,
  output logic pass,
  output logic [$clog2(N_PATTERNS+1)-1:0] pattern_cnt
);

  localparam int PC_W = $clog2(N_PATTERNS+1);
  localparam int SC_W = (N_SHIFT > 1) ? $clog2(N_SHIFT) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(N_SHIFT-1);
  localparam logic [PC_W-1:0] PC_MAX = PC_W'(N_PATTERNS);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(N_PATTERNS-1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    UNLOAD  = 3'd4,
    COMPARE = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t state_q;
  state_t state_d;
  logic [SC_W-1:0] sc_q;
  logic [PC_W-1:0] pc_q;
  logic pass_q;
  logic sc_last;
  logic go;

  assign sc_last = (sc_q == SC_LAST);
  assign go = start &&
              (state_q == IDLE || state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = INIT;
      DONE:    if (start) state_d = INIT;
      INIT:    state_d = SHIFT;
      SHIFT:   if (sc_last) state_d = CAPTURE;
      // pc_q still holds the pre-increment count here
      CAPTURE: state_d = (pc_q < PC_LAST) ? SHIFT
                                          : UNLOAD;
      UNLOAD:  if (sc_last) state_d = COMPARE;
      COMPARE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sc_q    <= '0;
      pc_q    <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // restart on every state change, hold at the end value
      if (state_d != state_q) sc_q <= '0;
      else if (!sc_last) sc_q <= sc_q + 1'b1;
      if (go) pc_q <= '0;
      else if (state_q == CAPTURE && pc_q != PC_MAX)
        pc_q <= pc_q + 1'b1;
      if (go) pass_q <= 1'b0;
      else if (state_q == COMPARE)
        pass_q <= (misr_sig == GOLDEN_SIG);
    end
  end

  assign lfsr_rst = (state_q == INIT);
  assign misr_rst = (state_q == INIT);
  assign lfsr_en  = (state_q == SHIFT);
  assign scan_en  = (state_q == SHIFT) ||
                    (state_q == UNLOAD);
  assign capture  = (state_q == CAPTURE);
  // first load: chain holds unknown data
  assign misr_en  = (state_q == SHIFT && pc_q != '0) ||
                    (state_q == UNLOAD);
  assign busy     = (state_q == INIT)    ||
                    (state_q == SHIFT)   ||
                    (state_q == CAPTURE) ||
                    (state_q == UNLOAD)  ||
                    (state_q == COMPARE);
  assign done     = (state_q == DONE);
  assign pass     = pass_q;
  assign pattern_cnt = pc_q;

endmodule

// File: tb/tb_lbist_ctrl.sv
// Bench for lbist_ctrl: two instances (4x3 and 1x1) against a schedule model.
// Expected output words are queued per cycle and popped by a monitor.
module tb_lbist_ctrl;

  localparam logic [7:0] G = 8'hA5;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [7:0] misr_sig;

  logic a_lr, a_le, a_se, a_cap, a_mr, a_me;
  logic a_busy, a_done, a_pass;
  logic [1:0] a_pc;
  logic b_lr, b_le, b_se, b_cap, b_mr, b_me;
  logic b_busy, b_done, b_pass;
  logic [0:0] b_pc;

  always #5 clk = ~clk;

  lbist_ctrl #(
    .N_SHIFT(4), .N_PATTERNS(3),
    .SIG_W(8), .GOLDEN_SIG(G)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start),
    .misr_sig(misr_sig),
    .lfsr_rst(a_lr), .lfsr_en(a_le),
    .scan_en(a_se), .capture(a_cap),
    .misr_rst(a_mr), .misr_en(a_me),
    .busy(a_busy), .done(a_done),
    .pass(a_pass), .pattern_cnt(a_pc)
  );

  lbist_ctrl #(
    .N_SHIFT(1), .N_PATTERNS(1),
    .SIG_W(8), .GOLDEN_SIG(G)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start),
    .misr_sig(misr_sig),
    .lfsr_rst(b_lr), .lfsr_en(b_le),
    .scan_en(b_se), .capture(b_cap),
    .misr_rst(b_mr), .misr_en(b_me),
    .busy(b_busy), .done(b_done),
    .pass(b_pass), .pattern_cnt(b_pc)
  );

  wire [16:0] act_a = {a_lr, a_le, a_se, a_cap,
                       a_mr, a_me, a_busy, a_done,
                       a_pass, 6'b0, a_pc};
  wire [16:0] act_b = {b_lr, b_le, b_se, b_cap,
                       b_mr, b_me, b_busy, b_done,
                       b_pass, 7'b0, b_pc};

  logic [16:0] exp_a[$];
  logic [16:0] exp_b[$];
  int n_chk = 0;
  int n_pass = 0;

  bit m_run[2];
  int m_off[2];
  bit m_done[2];
  bit m_pass[2];

  // Output word for a run of P patterns of S shift cycles, given
  // the offset since INIT (busy phase) or the idle/done status.
  function automatic logic [16:0] expv(
    input int S, input int P, input bit run,
    input int off, input bit dn, input bit ps);
    logic lr, le, se, cap, mr, me, bz, d, p;
    int pc, k, j, body;
    lr = 0; le = 0; se = 0; cap = 0; mr = 0;
    me = 0; bz = 0; d = 0; p = 0; pc = 0;
    body = 1 + P * (S + 1);
    if (!run) begin
      d = dn;
      p = ps;
      pc = dn ? P : 0;
    end else begin
      bz = 1;
      if (off == 0) begin
        lr = 1;
        mr = 1;
      end else if (off < body) begin
        k = (off - 1) / (S + 1);
        j = (off - 1) % (S + 1);
        pc = k;
        if (j < S) begin
          se = 1;
          le = 1;
          me = (k != 0);
        end else cap = 1;
      end else if (off < body + S) begin
        se = 1;
        me = 1;
        pc = P;
      end else pc = P;
    end
    return {lr, le, se, cap, mr, me, bz, d, p, 8'(pc)};
  endfunction

  task automatic mstep(input int i, input int S,
                       input int P, input bit r,
                       input bit s, input logic [7:0] g);
    int total;
    total = 2 + P * (S + 1) + S;
    if (r) begin
      m_run[i] = 0;
      m_done[i] = 0;
      m_pass[i] = 0;
    end else if (m_run[i]) begin
      if (m_off[i] == total - 1) begin
        m_run[i] = 0;
        m_done[i] = 1;
        m_pass[i] = (g == G);
      end else m_off[i]++;
    end else if (s) begin
      m_run[i] = 1;
      m_off[i] = 0;
      m_done[i] = 0;
      m_pass[i] = 0;
    end
  endtask

  task automatic cyc(input bit r, input bit s,
                     input logic [7:0] g);
    rst = r;
    start = s;
    misr_sig = g;
    @(posedge clk);
    mstep(0, 4, 3, r, s, g);
    mstep(1, 1, 1, r, s, g);
    exp_a.push_back(expv(4, 3, m_run[0], m_off[0],
                         m_done[0], m_pass[0]));
    exp_b.push_back(expv(1, 1, m_run[1], m_off[1],
                         m_done[1], m_pass[1]));
    #1;
  endtask

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
  endtask

  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (exp_a.size() > 0) begin
        e = exp_a.pop_front();
        n_chk++;
        if (act_a === e) n_pass++;
        else $display("FAIL ctl_a t=%0t got %h expected %h",
                      $time, act_a, e);
      end
      if (exp_b.size() > 0) begin
        e = exp_b.pop_front();
        n_chk++;
        if (act_b === e) n_pass++;
        else $display("FAIL ctl_b t=%0t got %h expected %h",
                      $time, act_b, e);
      end
    end
  end

  initial begin
    int ba, bb;
    bit r, s;
    logic [7:0] g;
    rst = 1'b1;
    start = 1'b0;
    misr_sig = '0;
    repeat (3) cyc(1, 0, 8'h00);
    cyc(0, 0, G);

    // matching signature, measure busy length
    cyc(0, 1, G);
    ba = 0;
    bb = 0;
    for (int k = 0; k < 60; k++) begin
      if (a_busy) ba++;
      if (b_busy) bb++;
      if (a_done) break;
      cyc(0, 0, G);
    end
    chk("busy_len_a", ba, 21);
    chk("busy_len_b", bb, 5);
    chk("pass_a", int'(a_pass), 1);
    chk("pass_b", int'(b_pass), 1);
    repeat (3) cyc(0, 0, G);

    // mismatching signature
    cyc(0, 1, G ^ 8'h01);
    repeat (25) cyc(0, 0, G ^ 8'h01);
    chk("fail_done_a", int'(a_done), 1);
    chk("fail_pass_a", int'(a_pass), 0);

    // abort in the middle of a run
    cyc(0, 1, G);
    repeat (9) cyc(0, 0, G);
    cyc(1, 0, G);
    repeat (25) cyc(0, 0, G);
    chk("abort_done_a", int'(a_done), 0);
    chk("abort_pc_a", int'(a_pc), 0);

    // level start: back-to-back runs
    repeat (50) cyc(0, 1, G);
    cyc(0, 0, G);

    for (int k = 0; k < 800; k++) begin
      r = ($urandom_range(0, 60) == 0);
      s = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) g = G;
      else g = G ^ 8'($urandom_range(1, 255));
      cyc(r, s, g);
    end

    repeat (2) cyc(0, 0, G);
    @(negedge clk);
    #1;
    chk("drain_a", exp_a.size(), 0);
    chk("drain_b", exp_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
